// File: rtl/button_pulse_gen.sv
// button_pulse_gen
// Push-button front end for the clock's display/edit state machine. It
// synchronises and debounces the active-low mode, adjust and increment keys.
// Each accepted press becomes a one-cycle, active-low, registered pulse.
// Mode and adjust pulses never overlap; mode wins a tie and adjust follows
// one cycle later.
// Optional build macro: BUTTON_AUTO_REPEAT_EN. When it is defined, a held
// increment key auto-repeats inc_btn after REPEAT_DELAY_CYCLES and then every
// REPEAT_PERIOD_CYCLES cycles.
module button_pulse_gen #(
  parameter int unsigned DEBOUNCE_CYCLES      = 2000000,
  parameter int unsigned REPEAT_DELAY_CYCLES  = 50000000,
  parameter int unsigned REPEAT_PERIOD_CYCLES = 10000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic mode_raw,
  input  logic adjust_raw,
  input  logic inc_raw,
  output logic mode_btn,
  output logic adjust_btn,
  output logic inc_btn
);

  localparam int N_KEYS     = 3;
  localparam int KEY_MODE   = 0;
  localparam int KEY_ADJUST = 1;
  localparam int KEY_INC    = 2;
  localparam int DB_W       = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  // A debounce window under two cycles, or a zero repeat interval, is meaningless.
  if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY_CYCLES < 1 || REPEAT_PERIOD_CYCLES < 1) begin : g_bad_params
    $error("button_pulse_gen: DEBOUNCE_CYCLES must be >= 2 and repeat intervals >= 1");
  end

  logic [N_KEYS-1:0] raw;
  logic [N_KEYS-1:0] sync_meta_q, sync_meta_d;
  logic [N_KEYS-1:0] sync_q, sync_d;
  logic [N_KEYS-1:0] stable_q, stable_d;
  logic [N_KEYS-1:0] stable_dly_q, stable_dly_d;
  logic [N_KEYS-1:0] press;
  logic [DB_W-1:0]   db_cnt_q [N_KEYS];
  logic [DB_W-1:0]   db_cnt_d [N_KEYS];

  logic pend_q, pend_d;
  logic mode_btn_q, mode_btn_d;
  logic adjust_btn_q, adjust_btn_d;
  logic inc_btn_q, inc_btn_d;
  logic adjust_fire;
  logic inc_fire;

  assign raw = {inc_raw, adjust_raw, mode_raw};

  // A press is the accepted level falling from 1 to 0. Release creates no event.
  assign press = stable_dly_q & ~stable_q;

  // Synchroniser chain and per-key debounce counter: a new level is accepted only after it has held unchanged.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch, so no path can infer a latch.
    sync_meta_d  = raw;
    sync_d       = sync_meta_q;
    stable_dly_d = stable_q;
    stable_d     = stable_q;
    for (int k = 0; k < N_KEYS; k++) begin
      db_cnt_d[k] = '0;
      if (sync_q[k] != stable_q[k]) begin
        if (db_cnt_q[k] == DB_LAST) begin
          stable_d[k] = sync_q[k];
        end else begin
          db_cnt_d[k] = db_cnt_q[k] + DB_W'(1);
        end
      end
    end
  end

  // Key state registers. All keys reset to "released" with their counters cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_meta_q  <= '1;
      sync_q       <= '1;
      stable_q     <= '1;
      stable_dly_q <= '1;
      // NOTE: the counter array is tiny and must restart from zero after a reset that lands mid-debounce, so it is reset like ordinary flops.
      for (int k = 0; k < N_KEYS; k++) begin
        db_cnt_q[k] <= '0;
      end
    end else begin
      // NOTE: state is updated with non-blocking assignments, so every flop samples values from before the edge.
      sync_meta_q  <= sync_meta_d;
      sync_q       <= sync_d;
      stable_q     <= stable_d;
      stable_dly_q <= stable_dly_d;
      for (int k = 0; k < N_KEYS; k++) begin
        db_cnt_q[k] <= db_cnt_d[k];
      end
    end
  end

`ifdef BUTTON_AUTO_REPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY_CYCLES > REPEAT_PERIOD_CYCLES) ?
                           int'(REPEAT_DELAY_CYCLES) : int'(REPEAT_PERIOD_CYCLES);
  localparam int REP_W   = $clog2(REP_MAX + 1);
  localparam logic [REP_W-1:0] REP_DELAY  = REP_W'(REPEAT_DELAY_CYCLES);
  localparam logic [REP_W-1:0] REP_PERIOD = REP_W'(REPEAT_PERIOD_CYCLES);

  logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
  logic             rep_phase_q, rep_phase_d;
  logic             rep_fire;

  // Repeat timer. It counts while inc is held: first the long delay, then the shorter period. Release clears it at once.
  always_comb begin
    rep_cnt_d   = '0;
    rep_phase_d = 1'b0;
    rep_fire    = 1'b0;
    if (!stable_q[KEY_INC]) begin
      rep_fire = rep_phase_q ? (rep_cnt_q == REP_PERIOD) : (rep_cnt_q == REP_DELAY);
      if (rep_fire) begin
        rep_cnt_d   = REP_W'(1);
        rep_phase_d = 1'b1;
      end else begin
        rep_cnt_d   = rep_cnt_q + REP_W'(1);
        rep_phase_d = rep_phase_q;
      end
    end
  end

  // Repeat timer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_cnt_q   <= '0;
      rep_phase_q <= 1'b0;
    end else begin
      rep_cnt_q   <= rep_cnt_d;
      rep_phase_q <= rep_phase_d;
    end
  end

  assign inc_fire = press[KEY_INC] | rep_fire;
`else
  assign inc_fire = press[KEY_INC];
`endif

  // Pulse shaping. Mode has priority; an adjust press that ties with mode is deferred by one cycle.
  always_comb begin
    adjust_fire  = (pend_q | press[KEY_ADJUST]) & ~press[KEY_MODE];
    pend_d       = (pend_q | press[KEY_ADJUST]) & press[KEY_MODE];
    mode_btn_d   = ~press[KEY_MODE];
    adjust_btn_d = ~adjust_fire;
    inc_btn_d    = ~inc_fire;
  end

  // Output registers. They idle high, so every output comes straight from a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q       <= 1'b0;
      mode_btn_q   <= 1'b1;
      adjust_btn_q <= 1'b1;
      inc_btn_q    <= 1'b1;
    end else begin
      pend_q       <= pend_d;
      mode_btn_q   <= mode_btn_d;
      adjust_btn_q <= adjust_btn_d;
      inc_btn_q    <= inc_btn_d;
    end
  end

  assign mode_btn   = mode_btn_q;
  assign adjust_btn = adjust_btn_q;
  assign inc_btn    = inc_btn_q;

endmodule

// File: tb/tb_button_pulse_gen.sv
// tb_button_pulse_gen
// Self-checking bench for button_pulse_gen with short timing parameters.
// The reference model works on the per-edge history of raw samples.
// - A level is accepted when the D samples taken two to D+1 edges earlier all
//   disagree with the current accepted level.
// - A press pulse appears one edge after acceptance.
// - Repeats are derived from the age of the press pulse.
module tb_button_pulse_gen;

  localparam int D  = 4;
  localparam int RD = 20;
  localparam int RP = 5;

  logic clk = 1'b0;
  logic rst_n;
  logic mode_raw, adjust_raw, inc_raw;
  logic mode_btn, adjust_btn, inc_btn;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state.
  int           edge_n;
  logic [D+1:0] hist [3];
  logic [2:0]   m_stable;
  logic [2:0]   m_press;
  logic         m_defer;
  logic         exp_mode, exp_adj, exp_inc;
  int           p_edge;
  bit           p_valid;

  button_pulse_gen #(
    .DEBOUNCE_CYCLES     (D),
    .REPEAT_DELAY_CYCLES (RD),
    .REPEAT_PERIOD_CYCLES(RP)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode_raw  (mode_raw),
    .adjust_raw(adjust_raw),
    .inc_raw   (inc_raw),
    .mode_btn  (mode_btn),
    .adjust_btn(adjust_btn),
    .inc_btn   (inc_btn)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int k = 0; k < 3; k++) hist[k] = '1;
    m_stable = 3'b111;
    m_press  = 3'b000;
    m_defer  = 1'b0;
    exp_mode = 1'b1;
    exp_adj  = 1'b1;
    exp_inc  = 1'b1;
    p_valid  = 1'b0;
    p_edge   = 0;
    edge_n   = 0;
  endtask

  // Advances the model by one rising edge. It computes the outputs expected in the cycle after that edge.
  task automatic model_step();
    logic [2:0] r;
    logic [2:0] newp;
    logic       rep;
    int         age;
    edge_n++;
    r   = {inc_raw, adjust_raw, mode_raw};
    rep = 1'b0;
`ifdef BUTTON_AUTO_REPEAT_EN
    if (p_valid && !m_stable[2]) begin
      age = edge_n - p_edge;
      if (age == RD || (age > RD && (age - RD) % RP == 0)) rep = 1'b1;
    end
`else
    age = 0;
`endif
    exp_mode = !m_press[0];
    exp_adj  = !((m_press[1] && !m_press[0]) || m_defer);
    exp_inc  = !(m_press[2] || rep);
    if (m_press[2]) begin
      p_edge  = edge_n;
      p_valid = 1'b1;
    end
    m_defer = m_press[1] && m_press[0];
    newp    = 3'b000;
    for (int k = 0; k < 3; k++) begin
      hist[k] = {hist[k][D:0], r[k]};
      if (hist[k][D+1:2] == {D{~m_stable[k]}}) begin
        m_stable[k] = ~m_stable[k];
        if (!m_stable[k]) newp[k] = 1'b1;
      end
    end
    m_press = newp;
    if (m_stable[2]) p_valid = 1'b0;
  endtask

  // One clock: the model follows the rising edge, and control returns at the falling edge for sampling.
  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    {mode_raw, adjust_raw, inc_raw} = 3'b111;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      tick();
      vectors++;
      if ({mode_btn, adjust_btn, inc_btn} !== 3'b111) begin
        miscompares++;
        $display("FAIL reset cycle %0d: outputs %b, expected 111", i, {mode_btn, adjust_btn, inc_btn});
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_clean_press();
    int s, pulses, pedge;
    s = edge_n + 1;
    pulses = 0;
    pedge = -1;
    for (int i = 0; i < 50; i++) begin
      mode_raw = (i < 30) ? 1'b0 : 1'b1;
      tick();
      vectors++;
      if ({mode_btn, adjust_btn, inc_btn} !== {exp_mode, exp_adj, exp_inc}) begin
        miscompares++;
        $display("FAIL clean_press edge %0d: outputs %b, expected %b", edge_n,
                 {mode_btn, adjust_btn, inc_btn}, {exp_mode, exp_adj, exp_inc});
      end
      if (!mode_btn) begin
        pulses++;
        pedge = edge_n;
      end
    end
    vectors++;
    if (pulses !== 1 || pedge !== s + 6) begin
      miscompares++;
      $display("FAIL clean_press_timing: %0d pulses after edge %0d, expected 1 after edge %0d", pulses, pedge, s + 6);
    end
  endtask

  task automatic test_bounce();
    logic pat [36];
    int   s, pulses, pedge;
    for (int i = 0; i < 36; i++) pat[i] = 1'b0;
    pat[2] = 1'b1; pat[3] = 1'b1; pat[6] = 1'b1; pat[7] = 1'b1;   // 0/1/0/1 phases, then 0 from index 8
    pat[24] = 1'b1; pat[25] = 1'b1;                               // release bounce 1/0, then 1 from index 28
    for (int i = 28; i < 36; i++) pat[i] = 1'b1;
    s = edge_n + 1 + 8;
    pulses = 0;
    pedge = -1;
    for (int i = 0; i < 46; i++) begin
      adjust_raw = (i < 36) ? pat[i] : 1'b1;
      tick();
      vectors++;
      if ({mode_btn, adjust_btn, inc_btn} !== {exp_mode, exp_adj, exp_inc}) begin
        miscompares++;
        $display("FAIL bounce edge %0d: outputs %b, expected %b", edge_n,
                 {mode_btn, adjust_btn, inc_btn}, {exp_mode, exp_adj, exp_inc});
      end
      if (!adjust_btn) begin
        pulses++;
        pedge = edge_n;
      end
    end
    vectors++;
    if (pulses !== 1 || pedge !== s + 6) begin
      miscompares++;
      $display("FAIL bounce_timing: %0d pulses after edge %0d, expected 1 after edge %0d", pulses, pedge, s + 6);
    end
  endtask

  task automatic test_simultaneous();
    int s, m_edge, a_edge;
    s = edge_n + 1;
    m_edge = -1;
    a_edge = -1;
    for (int i = 0; i < 35; i++) begin
      mode_raw   = (i < 15) ? 1'b0 : 1'b1;
      adjust_raw = (i < 15) ? 1'b0 : 1'b1;
      tick();
      vectors++;
      if ({mode_btn, adjust_btn, inc_btn} !== {exp_mode, exp_adj, exp_inc}) begin
        miscompares++;
        $display("FAIL simultaneous edge %0d: outputs %b, expected %b", edge_n,
                 {mode_btn, adjust_btn, inc_btn}, {exp_mode, exp_adj, exp_inc});
      end
      if (!mode_btn && !adjust_btn) begin
        miscompares++;
        $display("FAIL simultaneous_overlap edge %0d: mode_btn and adjust_btn both 0, expected never both", edge_n);
      end
      if (!mode_btn) m_edge = edge_n;
      if (!adjust_btn) a_edge = edge_n;
    end
    vectors++;
    if (m_edge !== s + 6 || a_edge !== s + 7) begin
      miscompares++;
      $display("FAIL simultaneous_order: mode after %0d adjust after %0d, expected %0d and %0d",
               m_edge, a_edge, s + 6, s + 7);
    end
  endtask

  task automatic test_reset_mid_debounce();
    int pulses, pedge;
    inc_raw = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    model_reset();
    #1;
    vectors++;
    if ({mode_btn, adjust_btn, inc_btn} !== 3'b111) begin
      miscompares++;
      $display("FAIL reset_async: outputs %b, expected 111", {mode_btn, adjust_btn, inc_btn});
    end
    @(negedge clk);
    tick();
    rst_n = 1'b1;
    pulses = 0;
    pedge = -1;
    for (int i = 0; i < 30; i++) begin
      inc_raw = (i < 15) ? 1'b0 : 1'b1;
      tick();
      vectors++;
      if ({mode_btn, adjust_btn, inc_btn} !== {exp_mode, exp_adj, exp_inc}) begin
        miscompares++;
        $display("FAIL reset_mid edge %0d: outputs %b, expected %b", edge_n,
                 {mode_btn, adjust_btn, inc_btn}, {exp_mode, exp_adj, exp_inc});
      end
      if (!inc_btn) begin
        pulses++;
        pedge = edge_n;
      end
    end
    vectors++;
    if (pulses !== 1 || pedge !== D + 3) begin
      miscompares++;
      $display("FAIL reset_mid_timing: %0d pulses after edge %0d, expected 1 after edge %0d", pulses, pedge, D + 3);
    end
  endtask

  task automatic test_auto_repeat();
    int pulses, want;
`ifdef BUTTON_AUTO_REPEAT_EN
    want = 6;   // press pulse plus repeats at P+20, +25, +30, +35, +40
`else
    want = 1;
`endif
    pulses = 0;
    // Held for 45 samples, so the accepted release lands before the repeat at P+45 would fall due.
    for (int i = 0; i < 70; i++) begin
      inc_raw = (i < 45) ? 1'b0 : 1'b1;
      tick();
      vectors++;
      if ({mode_btn, adjust_btn, inc_btn} !== {exp_mode, exp_adj, exp_inc}) begin
        miscompares++;
        $display("FAIL auto_repeat edge %0d: outputs %b, expected %b", edge_n,
                 {mode_btn, adjust_btn, inc_btn}, {exp_mode, exp_adj, exp_inc});
      end
      if (!inc_btn) pulses++;
    end
    vectors++;
    if (pulses !== want) begin
      miscompares++;
      $display("FAIL auto_repeat_count: %0d inc pulses, expected %0d", pulses, want);
    end
  endtask

  task automatic test_glitch();
    int pulses;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      mode_raw = (i < 3) ? 1'b0 : 1'b1;
      tick();
      vectors++;
      if ({mode_btn, adjust_btn, inc_btn} !== {exp_mode, exp_adj, exp_inc}) begin
        miscompares++;
        $display("FAIL glitch edge %0d: outputs %b, expected %b", edge_n,
                 {mode_btn, adjust_btn, inc_btn}, {exp_mode, exp_adj, exp_inc});
      end
      if (!mode_btn) pulses++;
    end
    vectors++;
    if (pulses !== 0) begin
      miscompares++;
      $display("FAIL glitch_count: %0d mode pulses, expected 0", pulses);
    end
  endtask

  task automatic test_random();
    int         hold [3];
    logic [2:0] lvl;
    lvl = 3'b111;
    for (int k = 0; k < 3; k++) hold[k] = 0;
    for (int i = 0; i < 3000; i++) begin
      for (int k = 0; k < 3; k++) begin
        if (hold[k] == 0) begin
          lvl[k]  = 1'($urandom_range(0, 1));
          hold[k] = $urandom_range(1, 12);
        end
        hold[k]--;
      end
      {inc_raw, adjust_raw, mode_raw} = lvl;
      if ($urandom_range(0, 399) == 0) begin
        rst_n = 1'b0;
        model_reset();
        tick();
        rst_n = 1'b1;
      end
      tick();
      vectors++;
      if ({mode_btn, adjust_btn, inc_btn} !== {exp_mode, exp_adj, exp_inc}) begin
        miscompares++;
        $display("FAIL random edge %0d: outputs %b, expected %b", edge_n,
                 {mode_btn, adjust_btn, inc_btn}, {exp_mode, exp_adj, exp_inc});
      end
      if (!mode_btn && !adjust_btn) begin
        miscompares++;
        $display("FAIL random_overlap edge %0d: mode_btn and adjust_btn both 0, expected never both", edge_n);
      end
    end
    {mode_raw, adjust_raw, inc_raw} = 3'b111;
    for (int i = 0; i < 20; i++) tick();
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_simultaneous();
    test_reset_mid_debounce();
    test_auto_repeat();
    test_glitch();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
